sockit_spi_dma_master: RTL and testbench

//  AXI4 initiator DMA engine for the SPI master: on a command, fetches a burst from memory
//  and streams it to the SPI write stream (TX), or drains the SPI read stream into memory (RX).

---
 rtl/axi4_pkg.sv | 24 ++
 rtl/sockit_spi_pkg.sv | 12 +
 rtl/axi4_if.sv | 55 +++++
 rtl/sockit_spi_if.sv | 11 +
 rtl/sockit_spi_dma_master.sv | 161 ++++++++++++++++
 tb/tb_sockit_spi_dma_master.sv | 284 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - AXI4 burst/response encodings and size helper
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef logic [2:0] size_t;

  // AxSIZE encoding for a data width given in bits
  function automatic size_t int2SIZE(input int dw);
    return size_t'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/sockit_spi_pkg.sv
// rtl/sockit_spi_pkg.sv - shared types for the SPI master datapath
package sockit_spi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - AXI4 bus bundle (IDs on request channels only)
interface axi4_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 1
);
  logic [IW-1:0]   AWID;
  logic [AW-1:0]   AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWLOCK;
  logic [3:0]      AWCACHE;
  logic [2:0]      AWPROT;
  logic [3:0]      AWQOS;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [IW-1:0]   ARID;
  logic [AW-1:0]   ARADDR;
  logic [7:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARLOCK;
  logic [3:0]      ARCACHE;
  logic [2:0]      ARPROT;
  logic [3:0]      ARQOS;
  logic            ARVALID;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport m (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/sockit_spi_if.sv
// rtl/sockit_spi_if.sv - SPI stream bundle: s drives data out, d takes data in
interface sockit_spi_if #(
  parameter int DW = 32
);
  logic          vld;
  logic [DW-1:0] dat;
  logic          rdy;

  modport s (output vld, dat, input rdy);
  modport d (input vld, dat, output rdy);
endinterface

// File: rtl/sockit_spi_dma_master.sv
// rtl/sockit_spi_dma_master.sv - single-burst AXI4 DMA initiator between SPI streams and memory
// TX reads a burst into the sdw stream, RX writes the sdr stream out as a burst.
module sockit_spi_dma_master
  import axi4_pkg::*;
  import sockit_spi_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic          cmd_dir,
  input  logic [AW-1:0] cmd_adr,
  input  logic [7:0]    cmd_len,
  output logic          sts_vld,
  output logic          sts_err,
  axi4_if.m             axi,
  sockit_spi_if.s       sdw,
  sockit_spi_if.d       sdr
);

  localparam int    BW   = DW / 8;
  localparam size_t SIZE = int2SIZE(DW);

  dma_state_t    state;
  dma_state_t    state_nxt;
  logic          dir_q;
  logic [AW-1:0] adr_q;
  logic [7:0]    len_q;
  logic [7:0]    cnt;
  logic          err;
  logic          arvalid_q;
  logic          awvalid_q;

  logic          accept;
  logic          reject;
  logic          tx_act;
  logic          rx_act;
  logic          r_hs;
  logic          w_hs;
  logic          b_hs;
  logic          last_beat;
  logic [13:0]   span_end;

  // End offset of the burst inside its 4 KB page; anything past 4096 crosses the page
  assign span_end  = 14'(cmd_adr[11:0]) + (14'(cmd_len) + 14'd1) * 14'(BW);
  assign reject    = ((cmd_adr & AW'(BW - 1)) != '0) || (span_end > 14'd4096);
  assign accept    = cmd_vld && (state == IDLE);
  assign tx_act    = (state == DATA) && !dir_q;
  assign rx_act    = (state == DATA) && dir_q;
  assign last_beat = (cnt == 8'd0);

  // Handshakes built from inputs and state only, so the ready outputs stay loop-free
  assign r_hs = tx_act && axi.RVALID && sdw.rdy;
  assign w_hs = rx_act && sdr.vld && axi.WREADY;
  assign b_hs = (state == RESP) && axi.BVALID;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      adr_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          dir_q     <= cmd_dir;
          adr_q     <= cmd_adr;
          len_q     <= cmd_len;
          cnt       <= cmd_len;
          err       <= reject;
          arvalid_q <= !reject && !cmd_dir;
          awvalid_q <= !reject && cmd_dir;
        end
        ADDR: begin
          if (axi.ARREADY) arvalid_q <= 1'b0;
          if (axi.AWREADY) awvalid_q <= 1'b0;
        end
        DATA: begin
          if (r_hs) begin
            cnt <= cnt - 8'd1;
            if ((axi.RRESP != RESP_OKAY) || (axi.RLAST != last_beat)) err <= 1'b1;
          end else if (w_hs) begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: if (b_hs && (axi.BRESP != RESP_OKAY)) err <= 1'b1;
        DONE: err <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_rdy   = 1'b0;
    sts_vld   = 1'b0;
    sts_err   = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (accept) state_nxt = reject ? DONE : ADDR;
      end
      ADDR: if ((arvalid_q && axi.ARREADY) || (awvalid_q && axi.AWREADY)) state_nxt = DATA;
      DATA: begin
        if (r_hs && axi.RLAST) state_nxt = DONE;
        else if (w_hs && last_beat) state_nxt = RESP;
      end
      RESP: if (b_hs) state_nxt = DONE;
      DONE: begin
        sts_vld   = 1'b1;
        sts_err   = err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign axi.ARID    = '0;
  assign axi.ARADDR  = adr_q;
  assign axi.ARLEN   = len_q;
  assign axi.ARSIZE  = SIZE;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARLOCK  = 1'b0;
  assign axi.ARCACHE = '0;
  assign axi.ARPROT  = '0;
  assign axi.ARQOS   = '0;
  assign axi.ARVALID = arvalid_q;

  assign axi.AWID    = '0;
  assign axi.AWADDR  = adr_q;
  assign axi.AWLEN   = len_q;
  assign axi.AWSIZE  = SIZE;
  assign axi.AWBURST = BURST_INCR;
  assign axi.AWLOCK  = 1'b0;
  assign axi.AWCACHE = '0;
  assign axi.AWPROT  = '0;
  assign axi.AWQOS   = '0;
  assign axi.AWVALID = awvalid_q;

  // Stream stalls pass straight through as AXI bubbles/back-pressure
  assign sdw.vld    = tx_act && axi.RVALID;
  assign sdw.dat    = axi.RDATA;
  assign axi.RREADY = tx_act && sdw.rdy;

  assign axi.WVALID = rx_act && sdr.vld;
  assign axi.WDATA  = sdr.dat;
  assign axi.WSTRB  = '1;
  assign axi.WLAST  = last_beat;
  assign sdr.rdy    = rx_act && axi.WREADY;

  assign axi.BREADY = (state == RESP);

endmodule

// File: tb/tb_sockit_spi_dma_master.sv
// tb/tb_sockit_spi_dma_master.sv - randomized bench with memory/stream reference model
module tb_sockit_spi_dma_master;
  import axi4_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_dir;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_len;
  logic        sts_vld;
  logic        sts_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [logic [31:0]];

  axi4_if #(.AW(32), .DW(32)) axi_bus ();
  sockit_spi_if #(.DW(32)) sdw_bus ();
  sockit_spi_if #(.DW(32)) sdr_bus ();

  sockit_spi_dma_master #(.DW(32), .AW(32)) dut (
    .ACLK    (clk),
    .ARESETn (rstn),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_dir (cmd_dir),
    .cmd_adr (cmd_adr),
    .cmd_len (cmd_len),
    .sts_vld (sts_vld),
    .sts_err (sts_err),
    .axi     (axi_bus),
    .sdw     (sdw_bus),
    .sdr     (sdr_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic rnd(input int stall);
    return (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic idle_inputs();
    cmd_vld         = 1'b0;
    axi_bus.ARREADY = 1'b0;
    axi_bus.AWREADY = 1'b0;
    axi_bus.RVALID  = 1'b0;
    axi_bus.RDATA   = '0;
    axi_bus.RRESP   = 2'b00;
    axi_bus.RLAST   = 1'b0;
    axi_bus.WREADY  = 1'b0;
    axi_bus.BVALID  = 1'b0;
    axi_bus.BRESP   = 2'b00;
    sdw_bus.rdy     = 1'b0;
    sdr_bus.vld     = 1'b0;
    sdr_bus.dat     = '0;
  endtask

  // One command end to end; the slave/stream model and expectations come from the command alone
  task automatic run_cmd(input logic dir, input logic [31:0] adr, input int len, input int stall,
                         input int err_beat, input int early_beat, input logic [1:0] bresp,
                         input int rst_beat, input logic [31:0] w0);
    logic [31:0] src[$];
    logic [31:0] a_addr;
    logic [7:0]  a_len;
    logic [2:0]  a_size;
    logic [1:0]  a_burst;
    int  beats, cyc, acc_cyc, first_av, sts_cyc, last_cyc, r_beat, n_sts, exp_beats;
    bit  accepted, saw_a, r_on, b_pend, got_sts, got_err, w_early, rv, wv, bv;
    bit  r_hs, w_hs, b_hs, rejected, exp_err;
    a_addr = '0; a_len = '0; a_size = '0; a_burst = '0;
    beats = 0; acc_cyc = 0; first_av = -1; sts_cyc = 0; last_cyc = 0; r_beat = 0; n_sts = 0;
    accepted = 0; saw_a = 0; r_on = 0; b_pend = 0; got_sts = 0; got_err = 0; w_early = 0;
    rv = 0; wv = 0; bv = 0; r_hs = 0; w_hs = 0; b_hs = 0;

    rejected = (adr[1:0] != 2'b00) || (int'(adr[11:0]) + (len + 1) * 4 > 4096);
    if (rejected) exp_beats = 0;
    else if (!dir && early_beat >= 0) exp_beats = early_beat + 1;
    else exp_beats = len + 1;
    exp_err = rejected ||
              (!dir && ((err_beat >= 0 && err_beat < exp_beats) || early_beat >= 0)) ||
              (dir && bresp != 2'b00);
    for (int i = 0; i <= len; i++) src.push_back((i == 0) ? w0 : $urandom);

    cmd_dir = dir;
    cmd_adr = adr;
    cmd_len = 8'(len);
    for (cyc = 0; cyc < 1000 && !got_sts; cyc++) begin
      @(negedge clk);
      if (rst_beat >= 0 && beats == rst_beat) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_arvalid", axi_bus.ARVALID, 0);
        chk("rst_awvalid", axi_bus.AWVALID, 0);
        chk("rst_wvalid", axi_bus.WVALID, 0);
        chk("rst_rready", axi_bus.RREADY, 0);
        chk("rst_bready", axi_bus.BREADY, 0);
        chk("rst_sdw_vld", sdw_bus.vld, 0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_sts_vld", sts_vld, 0);
        idle_inputs();
        repeat (4) begin
          @(negedge clk);
          #1;
          if (sts_vld) n_sts++;
        end
        chk("rst_no_sts", n_sts, 0);
        return;
      end
      cmd_vld         = !accepted;
      axi_bus.ARREADY = rnd(stall);
      axi_bus.AWREADY = rnd(stall);
      if (r_hs) rv = 0;
      if (r_on && !rv) rv = rnd(stall);
      axi_bus.RVALID = rv;
      axi_bus.RDATA  = rv ? rd(a_addr + 32'(4 * r_beat)) : 32'h0;
      axi_bus.RRESP  = (rv && r_beat == err_beat) ? RESP_SLVERR : RESP_OKAY;
      axi_bus.RLAST  = rv && (r_beat == int'(a_len) || r_beat == early_beat);
      sdw_bus.rdy    = rnd(stall);
      if (w_hs) wv = 0;
      if (!wv && beats < src.size()) wv = rnd(stall);
      sdr_bus.vld    = wv;
      sdr_bus.dat    = wv ? src[beats] : 32'h0;
      axi_bus.WREADY = rnd(stall);
      if (b_hs) bv = 0;
      if (b_pend && !bv) bv = rnd(stall);
      axi_bus.BVALID = bv;
      axi_bus.BRESP  = bresp;
      #1;
      if (cmd_vld && cmd_rdy) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
      if (first_av < 0 && (axi_bus.ARVALID || axi_bus.AWVALID)) first_av = cyc;
      if (axi_bus.ARVALID && axi_bus.ARREADY) begin
        saw_a = 1; a_addr = axi_bus.ARADDR; a_len = axi_bus.ARLEN;
        a_size = axi_bus.ARSIZE; a_burst = axi_bus.ARBURST;
        r_on = 1; r_beat = 0;
      end
      if (axi_bus.AWVALID && axi_bus.AWREADY) begin
        saw_a = 1; a_addr = axi_bus.AWADDR; a_len = axi_bus.AWLEN;
        a_size = axi_bus.AWSIZE; a_burst = axi_bus.AWBURST;
      end
      r_hs = axi_bus.RVALID && axi_bus.RREADY;
      chk("tx_hs_align", sdw_bus.vld && sdw_bus.rdy, r_hs);
      if (r_hs) begin
        chk("tx_data", sdw_bus.dat, rd(adr + 32'(4 * beats)));
        beats++;
        r_beat++;
        if (axi_bus.RLAST) begin
          r_on = 0;
          last_cyc = cyc;
        end
      end
      if (axi_bus.WVALID && !saw_a) w_early = 1;
      w_hs = axi_bus.WVALID && axi_bus.WREADY;
      chk("rx_hs_align", sdr_bus.vld && sdr_bus.rdy, w_hs);
      if (w_hs) begin
        chk("rx_wdata", axi_bus.WDATA, src[beats]);
        chk("rx_wlast", axi_bus.WLAST, beats == len);
        chk("rx_wstrb", axi_bus.WSTRB, 4'hf);
        mem[a_addr + 32'(4 * beats)] = axi_bus.WDATA;
        beats++;
        if (beats == len + 1) b_pend = 1;
      end
      b_hs = axi_bus.BVALID && axi_bus.BREADY;
      if (b_hs) begin
        b_pend = 0;
        last_cyc = cyc;
      end
      if (sts_vld) begin
        got_sts = 1;
        got_err = sts_err;
        sts_cyc = cyc;
      end
    end

    if (!got_sts) chk("sts_timeout", 0, 1);
    chk("sts_err", got_err, exp_err);
    chk("beats", beats, exp_beats);
    if (rejected) begin
      chk("rej_no_bus", saw_a, 0);
      chk("rej_latency", (sts_cyc - acc_cyc >= 1) && (sts_cyc - acc_cyc <= 2), 1);
    end else begin
      chk("a_addr", a_addr, adr);
      chk("a_len", a_len, 8'(len));
      chk("a_size", a_size, 3'd2);
      chk("a_burst", a_burst, 2'b01);
      chk("a_latency", first_av - acc_cyc, 1);
      chk("sts_latency", sts_cyc - last_cyc, 1);
      if (dir) begin
        chk("w_before_aw", w_early, 0);
        for (int i = 0; i <= len; i++) chk("rx_mem", rd(adr + 32'(4 * i)), src[i]);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("sts_pulse", sts_vld, 0);
  endtask

  initial begin
    logic        rdir;
    logic [31:0] radr;
    int          rlen;
    int          rerr;
    logic [1:0]  rbresp;
    rstn    = 1'b0;
    cmd_dir = 1'b0;
    cmd_adr = '0;
    cmd_len = '0;
    idle_inputs();
    sdw_bus.rdy     = 1'b1;
    sdr_bus.vld     = 1'b1;
    axi_bus.WREADY  = 1'b1;
    axi_bus.RVALID  = 1'b1;
    axi_bus.BVALID  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_rdy", cmd_rdy, 1);
    chk("reset_arvalid", axi_bus.ARVALID, 0);
    chk("reset_awvalid", axi_bus.AWVALID, 0);
    chk("reset_wvalid", axi_bus.WVALID, 0);
    chk("reset_rready", axi_bus.RREADY, 0);
    chk("reset_bready", axi_bus.BREADY, 0);
    chk("reset_sdw_vld", sdw_bus.vld, 0);
    chk("reset_sdr_rdy", sdr_bus.rdy, 0);
    chk("reset_sts_vld", sts_vld, 0);
    chk("reset_sts_err", sts_err, 0);
    idle_inputs();
    rstn = 1'b1;

    for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    run_cmd(1'b0, 32'h1000, 3, 0, -1, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b1, 32'h2000, 0, 0, -1, -1, 2'b00, -1, 32'hDEADBEEF);
    run_cmd(1'b0, 32'h1100, 3, 0, 2, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b1, 32'h2100, 2, 0, -1, -1, 2'b11, -1, $urandom);
    run_cmd(1'b0, 32'h0FF8, 3, 0, -1, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b1, 32'h1002, 0, 0, -1, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b1, 32'h0FF8, 3, 0, -1, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b0, 32'h0FF0, 3, 1, -1, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b0, 32'h3000, 3, 1, -1, 1, 2'b00, -1, 32'h0);

    for (int n = 0; n < 24; n++) begin
      rdir   = 1'($urandom_range(0, 1));
      radr   = $urandom & 32'h0000_3FFC;
      if ($urandom_range(0, 7) == 0) radr = radr | 32'h1;
      rlen   = $urandom_range(0, 31);
      rerr   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rlen) : -1;
      rbresp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      run_cmd(rdir, radr, rlen, 1, rerr, -1, rbresp, -1, $urandom);
    end

    run_cmd(1'b0, 32'h1000, 3, 0, -1, -1, 2'b00, 2, 32'h0);
    run_cmd(1'b0, 32'h1000, 3, 1, -1, -1, 2'b00, -1, 32'h0);
    run_cmd(1'b1, 32'h2200, 7, 1, -1, -1, 2'b00, -1, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
